// File: rtl/victimcache_requester.sv
// Victim-cache miss requester: optionally writes a victim line downstream, then
// reads the missing line and returns it upstream with a one-cycle response pulse.
module victimcache_requester #(
  parameter logic [15:0] CNT_INIT = 16'h0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [15:0]  req_addr,
  input  logic         evict_valid,
  input  logic         evict_dirty,
  input  logic [15:0]  evict_addr,
  input  logic [255:0] evict_data,
  output logic         req_ready,
  output logic         req_resp,
  output logic [255:0] fill_data,
  output logic         mem_read,
  output logic         mem_write,
  output logic [15:0]  mem_address,
  output logic [255:0] mem_wdata,
  output logic         dirty,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp,
  output logic [15:0]  evict_count,
  output logic [15:0]  fill_count
);
  typedef enum logic [1:0] {IDLE, EVICT, FILL, DONE} state_t;

  state_t      state;
  logic        evict_dirty_q;
  logic [10:0] req_line_q;

  // Line-offset bits of the incoming addresses are dropped on purpose.
  logic unused_offsets;
  assign unused_offsets = ^{req_addr[4:0], evict_addr[4:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      evict_dirty_q <= 1'b0;
      req_line_q    <= '0;
      mem_address   <= '0;
      mem_wdata     <= '0;
      fill_data     <= '0;
      evict_count   <= CNT_INIT;
      fill_count    <= CNT_INIT;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_line_q    <= req_addr[15:5];
          evict_dirty_q <= evict_dirty;
          mem_wdata     <= evict_data;
          if (evict_valid) begin
            state       <= EVICT;
            mem_address <= {evict_addr[15:5], 5'b0};
          end else begin
            state       <= FILL;
            mem_address <= {req_addr[15:5], 5'b0};
          end
        end
        EVICT: if (mem_resp) begin
          state       <= FILL;
          mem_address <= {req_line_q, 5'b0};
          if (evict_count != 16'hFFFF) evict_count <= evict_count + 16'd1;
        end
        FILL: if (mem_resp) begin
          state     <= DONE;
          fill_data <= mem_rdata;
          if (fill_count != 16'hFFFF) fill_count <= fill_count + 16'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes come straight off the state register, so EVICT->FILL swaps them on one edge.
  assign req_ready = (state == IDLE);
  assign req_resp  = (state == DONE);
  assign mem_write = (state == EVICT);
  assign mem_read  = (state == FILL);
  assign dirty     = mem_write & evict_dirty_q;
endmodule

// File: tb/tb_victimcache_requester.sv
// Directed bench for victimcache_requester: table of miss transactions plus
// hand-written reset, spurious-response and counter-saturation sequences.
module tb_victimcache_requester;
  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, evict_valid, evict_dirty, mem_resp;
  logic [15:0]  req_addr, evict_addr;
  logic [255:0] evict_data, mem_rdata;
  logic         req_ready, req_resp, mem_read, mem_write, dirty;
  logic [255:0] fill_data, mem_wdata;
  logic [15:0]  mem_address, evict_count, fill_count;

  logic         s_req_valid;
  logic         s_req_ready, s_req_resp, s_mem_read, s_mem_write, s_dirty;
  logic [255:0] s_fill_data, s_mem_wdata;
  logic [15:0]  s_mem_address, s_evict_count, s_fill_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_ec = 16'd0;
  logic [15:0] exp_fc = 16'd0;

  always #5 clk = ~clk;

  victimcache_requester dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .evict_valid(evict_valid), .evict_dirty(evict_dirty), .evict_addr(evict_addr),
    .evict_data(evict_data), .req_ready(req_ready), .req_resp(req_resp),
    .fill_data(fill_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .dirty(dirty),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .evict_count(evict_count), .fill_count(fill_count)
  );

  // Second instance starts its counters near the top so saturation is reachable quickly.
  victimcache_requester #(.CNT_INIT(16'hFFFE)) sat (
    .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_addr(16'h4321),
    .evict_valid(1'b0), .evict_dirty(1'b0), .evict_addr(16'h0000),
    .evict_data(256'h0), .req_ready(s_req_ready), .req_resp(s_req_resp),
    .fill_data(s_fill_data), .mem_read(s_mem_read), .mem_write(s_mem_write),
    .mem_address(s_mem_address), .mem_wdata(s_mem_wdata), .dirty(s_dirty),
    .mem_rdata(256'hBEEF), .mem_resp(1'b1),
    .evict_count(s_evict_count), .fill_count(s_fill_count)
  );

  typedef struct {
    logic [15:0]  req_addr;
    logic         evict_valid;
    logic         evict_dirty;
    logic [15:0]  evict_addr;
    logic [255:0] evict_data;
    logic [255:0] rdata;
    int           evict_dly;
    int           fill_dly;
    logic [15:0]  exp_eaddr;
    logic [15:0]  exp_faddr;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic scramble();
    req_valid   = 1'($urandom);
    req_addr    = 16'($urandom);
    evict_valid = 1'($urandom);
    evict_dirty = 1'($urandom);
    evict_addr  = 16'($urandom);
    evict_data  = {8{$urandom}};
  endtask

  task automatic run_txn(input vec_t v);
    @(negedge clk);
    chk("idle_ready", 256'(req_ready), 256'(1'b1));
    req_valid = 1'b1; req_addr = v.req_addr; evict_valid = v.evict_valid;
    evict_dirty = v.evict_dirty; evict_addr = v.evict_addr; evict_data = v.evict_data;
    @(negedge clk);
    if (v.evict_valid) begin
      for (int k = 0; k <= v.evict_dly; k++) begin
        chk("evict_write", 256'(mem_write), 256'(1'b1));
        chk("evict_read", 256'(mem_read), 256'(1'b0));
        chk("evict_dirty", 256'(dirty), 256'(v.evict_dirty));
        chk("evict_addr", 256'(mem_address), 256'(v.exp_eaddr));
        chk("evict_wdata", mem_wdata, v.evict_data);
        chk("evict_ready", 256'(req_ready), 256'(1'b0));
        scramble();
        mem_resp = (k == v.evict_dly);
        @(negedge clk);
        mem_resp = 1'b0;
      end
      exp_ec = (exp_ec == 16'hFFFF) ? exp_ec : exp_ec + 16'd1;
    end
    for (int k = 0; k <= v.fill_dly; k++) begin
      chk("fill_read", 256'(mem_read), 256'(1'b1));
      chk("fill_write", 256'(mem_write), 256'(1'b0));
      chk("fill_dirty", 256'(dirty), 256'(1'b0));
      chk("fill_addr", 256'(mem_address), 256'(v.exp_faddr));
      chk("fill_ready", 256'(req_ready), 256'(1'b0));
      chk("fill_noresp", 256'(req_resp), 256'(1'b0));
      scramble();
      mem_resp  = (k == v.fill_dly);
      mem_rdata = mem_resp ? v.rdata : {8{$urandom}};
      @(negedge clk);
      mem_resp = 1'b0;
    end
    exp_fc = (exp_fc == 16'hFFFF) ? exp_fc : exp_fc + 16'd1;
    req_valid = 1'b0;
    chk("done_resp", 256'(req_resp), 256'(1'b1));
    chk("done_strobes", 256'({mem_read, mem_write, dirty}), 256'(3'b000));
    chk("fill_data", fill_data, v.rdata);
    chk("evict_count", 256'(evict_count), 256'(exp_ec));
    chk("fill_count", 256'(fill_count), 256'(exp_fc));
    @(negedge clk);
    chk("resp_pulse", 256'(req_resp), 256'(1'b0));
    chk("back_idle", 256'(req_ready), 256'(1'b1));
  endtask

  initial begin
    tbl[0] = '{16'h1234, 1'b0, 1'b0, 16'h0000, 256'h0, 256'hA5, 0, 0, 16'h0000, 16'h1220};
    tbl[1] = '{16'h0100, 1'b1, 1'b1, 16'h8041, 256'h5A, 256'h77, 3, 3, 16'h8040, 16'h0100};
    tbl[2] = '{16'hFFFF, 1'b1, 1'b0, 16'h001F, {8{32'hDEADBEEF}}, {4{64'h0123456789ABCDEF}}, 0, 0, 16'h0000, 16'hFFE0};
    tbl[3] = '{16'h7FE0, 1'b0, 1'b0, 16'h0000, 256'h0, {256{1'b1}}, 0, 2, 16'h0000, 16'h7FE0};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; evict_valid = 1'b0; evict_dirty = 1'b0;
    evict_addr = '0; evict_data = '0; mem_rdata = '0; mem_resp = 1'b0; s_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 256'(req_ready), 256'(1'b1));
    chk("rst_resp", 256'(req_resp), 256'(1'b0));
    chk("rst_strobes", 256'({mem_read, mem_write, dirty}), 256'(3'b000));
    chk("rst_addr", 256'(mem_address), 256'(16'h0));
    chk("rst_wdata", mem_wdata, 256'h0);
    chk("rst_fill", fill_data, 256'h0);
    chk("rst_counts", 256'({evict_count, fill_count}), 256'(32'h0));

    for (int i = 0; i < 4; i++) run_txn(tbl[i]);

    // Spurious response in IDLE must not move anything.
    mem_resp = 1'b1; mem_rdata = {8{32'hCAFEF00D}};
    repeat (2) @(negedge clk);
    chk("spur_ready", 256'(req_ready), 256'(1'b1));
    chk("spur_resp", 256'(req_resp), 256'(1'b0));
    chk("spur_strobes", 256'({mem_read, mem_write}), 256'(2'b00));
    chk("spur_counts", 256'({evict_count, fill_count}), 256'({exp_ec, exp_fc}));
    chk("spur_fill", fill_data, tbl[3].rdata);
    mem_resp = 1'b0;

    // Reset during FILL, colliding with mem_resp and req_valid, abandons the request.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 16'h2468; evict_valid = 1'b0;
    @(negedge clk);
    chk("midfill_read", 256'(mem_read), 256'(1'b1));
    reset = 1'b1; mem_resp = 1'b1; mem_rdata = 256'h99;
    @(negedge clk);
    reset = 1'b0; mem_resp = 1'b0; req_valid = 1'b0;
    exp_ec = 16'd0; exp_fc = 16'd0;
    chk("midrst_ready", 256'(req_ready), 256'(1'b1));
    chk("midrst_resp", 256'(req_resp), 256'(1'b0));
    chk("midrst_strobes", 256'({mem_read, mem_write, dirty}), 256'(3'b000));
    chk("midrst_addr", 256'(mem_address), 256'(16'h0));
    chk("midrst_fill", fill_data, 256'h0);
    chk("midrst_wdata", mem_wdata, 256'h0);
    chk("midrst_counts", 256'({evict_count, fill_count}), 256'(32'h0));
    @(negedge clk);
    chk("midrst_noresp", 256'(req_resp), 256'(1'b0));
    chk("midrst_counts2", 256'({evict_count, fill_count}), 256'(32'h0));

    // Saturation: two back-to-back fills from FFFE, resp tied high.
    chk("sat_start", 256'(s_fill_count), 256'(16'hFFFE));
    s_req_valid = 1'b1;
    @(negedge clk);
    chk("sat_fill_state", 256'(s_mem_read), 256'(1'b1));
    @(negedge clk);
    chk("sat_first", 256'(s_fill_count), 256'(16'hFFFF));
    chk("sat_resp", 256'(s_req_resp), 256'(1'b1));
    repeat (3) @(negedge clk);
    chk("sat_second_resp", 256'(s_req_resp), 256'(1'b1));
    s_req_valid = 1'b0;
    chk("sat_hold", 256'(s_fill_count), 256'(16'hFFFF));
    chk("sat_evict", 256'(s_evict_count), 256'(16'hFFFE));
    chk("sat_fill_data", s_fill_data, 256'hBEEF);
    repeat (2) @(negedge clk);
    chk("sat_final", 256'(s_fill_count), 256'(16'hFFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
